// File: rtl/i2s_receiver_if.sv
// Frame hand-off port of the I2S receiver: held left/right samples with a valid/ready handshake.
interface i2s_receiver_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] left_o;
  logic [DATA_WIDTH-1:0] right_o;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (output left_o, output right_o, output frame_valid, input frame_ready);
  modport slave  (input left_o, input right_o, input frame_valid, output frame_ready);
endinterface

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCK/LRCK/DIN on clk, de-serialises stereo words
// (MSB first, one-BCK delay) and offers complete frames through a one-frame holding register.
module i2s_receiver #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SLOT_MAX   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i2s_bck,
  input  logic           i2s_lrck,
  input  logic           i2s_din,
  i2s_receiver_if.master frame,
  output logic           overrun,
  output logic           sync_err,
  output logic           locked
);

  localparam int unsigned CNT_W = $clog2(SLOT_MAX + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    WAIT_R   = 2'd1,
    WAIT_F   = 2'd2
  } state_t;

  logic [2:0]            bck_sync;
  logic [1:0]            lrck_sync;
  logic [1:0]            din_sync;
  logic                  lrck_prev, lrck_prev_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic [DATA_WIDTH-1:0] left_buf, left_buf_n;
  logic [DATA_WIDTH-1:0] left_q, left_n;
  logic [DATA_WIDTH-1:0] right_q, right_n;
  logic                  valid_q, valid_n;
  logic                  overrun_n, sync_err_n, locked_n;
  state_t                state, state_n;

  logic                  strobe_c, boundary_c, complete_c;
  logic [DATA_WIDTH-1:0] sh_wr_c;
  logic [CNT_W-1:0]      cnt_inc_c;

  assign frame.left_o      = left_q;
  assign frame.right_o     = right_q;
  assign frame.frame_valid = valid_q;

  // Next-state and output decode; capture only acts on the BCK rising-edge strobe.
  always_comb begin
    lrck_prev_n = lrck_prev;
    cnt_n       = cnt;
    sh_n        = sh;
    left_buf_n  = left_buf;
    left_n      = left_q;
    right_n     = right_q;
    valid_n     = valid_q;
    overrun_n   = 1'b0;
    sync_err_n  = 1'b0;
    state_n     = state;
    complete_c  = 1'b0;

    strobe_c   = bck_sync[1] & ~bck_sync[2];
    boundary_c = strobe_c & (lrck_sync[1] != lrck_prev);
    cnt_inc_c  = (cnt == CNT_W'(SLOT_MAX)) ? cnt : cnt + CNT_W'(1);

    // Bits beyond DATA_WIDTH fall through without matching any position.
    sh_wr_c = sh;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (cnt == CNT_W'(DATA_WIDTH - 1 - i)) sh_wr_c[i] = din_sync[1];
    end

    if (strobe_c) begin
      lrck_prev_n = lrck_sync[1];
      if (!boundary_c) begin
        sh_n  = sh_wr_c;
        cnt_n = cnt_inc_c;
        if (cnt_inc_c == CNT_W'(SLOT_MAX)) begin
          sync_err_n = 1'b1;
          state_n    = UNLOCKED;
          cnt_n      = '0;
          sh_n       = '0;
        end
      end else begin
        // The boundary strobe carries the LSB slot of the word that is ending.
        sh_n  = '0;
        cnt_n = '0;
        case (state)
          UNLOCKED: if (!lrck_sync[1]) state_n = WAIT_R;
          WAIT_R: if (lrck_sync[1]) begin
            left_buf_n = sh_wr_c;
            state_n    = WAIT_F;
          end
          WAIT_F: if (!lrck_sync[1]) begin
            complete_c = 1'b1;
            state_n    = WAIT_R;
          end
          default: state_n = UNLOCKED;
        endcase
      end
    end

    if (complete_c && (!valid_q || frame.frame_ready)) begin
      left_n  = left_buf;
      right_n = sh_wr_c;
      valid_n = 1'b1;
    end else if (complete_c) begin
      overrun_n = 1'b1;
    end else if (valid_q && frame.frame_ready) begin
      valid_n = 1'b0;
    end

    locked_n = (state_n != UNLOCKED);
  end

  // State register, synchronisers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      din_sync  <= '0;
      lrck_prev <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      left_buf  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
      state     <= UNLOCKED;
    end else begin
      bck_sync  <= {bck_sync[1:0], i2s_bck};
      lrck_sync <= {lrck_sync[0], i2s_lrck};
      din_sync  <= {din_sync[0], i2s_din};
      lrck_prev <= lrck_prev_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      left_buf  <= left_buf_n;
      left_q    <= left_n;
      right_q   <= right_n;
      valid_q   <= valid_n;
      overrun   <= overrun_n;
      sync_err  <= sync_err_n;
      locked    <= locked_n;
      state     <= state_n;
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: an I2S master model drives frames, a monitor checks handed-off frames.
module tb_i2s_receiver;

  localparam int unsigned DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic bck   = 1'b0;
  logic lrck  = 1'b0;
  logic din   = 1'b0;
  logic overrun, sync_err, locked;
  logic prev_lsb = 1'b0;

  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;
  int serr_cnt = 0;
  logic [31:0] exp_q[$];

  i2s_receiver_if #(.DATA_WIDTH(DW)) fif ();

  i2s_receiver #(.DATA_WIDTH(DW), .SLOT_MAX(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i2s_bck  (bck),
    .i2s_lrck (lrck),
    .i2s_din  (din),
    .frame    (fif),
    .overrun  (overrun),
    .sync_err (sync_err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted frame, counts status pulses.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && fif.frame_valid && fif.frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual L=%h R=%h required none", fif.left_o, fif.right_o);
      end else begin
        e = exp_q.pop_front();
        chk("frame_left", 32'(fif.left_o), 32'(e[31:16]));
        chk("frame_right", 32'(fif.right_o), 32'(e[15:0]));
      end
    end
    if (overrun) ovr_cnt++;
    if (sync_err) serr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One BCK period (16 clk): data/LRCK change while BCK low, receiver samples on the rise.
  task automatic send_bit(input logic l, input logic d);
    bck = 1'b0; lrck = l; din = d;
    tick(8);
    bck = 1'b1;
    tick(8);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, (i == 0) ? prev_lsb : l[n - i]);
    for (int i = 0; i < n; i++) send_bit(1'b1, (i == 0) ? l[0] : r[n - i]);
    prev_lsb = r[0];
  endtask

  task automatic preamble();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    prev_lsb = 1'b0;
  endtask

  // Trailing 1->0 boundary that delivers the LSB of the last right word.
  task automatic tail();
    send_bit(1'b0, prev_lsb);
    bck = 1'b0;
    tick(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic drain(input string name);
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual=%0d pending frames required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int ovr0, serr0;
    fif.frame_ready = 1'b1;
    tick(2);
    chk("reset_valid", 32'(fif.frame_valid), 32'd0);
    chk("reset_left", 32'(fif.left_o), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 16-bit frames, first frame after lock must be exact.
    do_reset(); preamble();
    exp_q.push_back(32'h8001_7FFE);
    exp_q.push_back(32'h8001_7FFE);
    send_frame(32'h8001, 32'h7FFE, 16);
    send_frame(32'h8001, 32'h7FFE, 16);
    tail(); drain("w16");
    chk("w16_locked", 32'(locked), 32'd1);

    // 32-bit slots keep only the top 16 bits.
    do_reset(); preamble(); serr0 = serr_cnt;
    exp_q.push_back(32'hDEAD_1234);
    send_frame(32'hDEADBEEF, 32'h12345678, 32);
    tail(); drain("w32");
    chk("w32_no_sync_err", 32'(serr_cnt - serr0), 32'd0);

    // 8-bit slots are zero-filled in the LSBs.
    do_reset(); preamble();
    exp_q.push_back(32'hA500_3C00);
    send_frame(32'hA5, 32'h3C, 8);
    tail(); drain("w8");

    // Overrun: consumer stalls across two frames.
    do_reset(); fif.frame_ready = 1'b0; preamble(); ovr0 = ovr_cnt;
    send_frame(32'h1111, 32'h2222, 16);
    send_frame(32'h3333, 32'h4444, 16);
    tail(); tick(8);
    chk("ovr_valid_held", 32'(fif.frame_valid), 32'd1);
    chk("ovr_left_held", 32'(fif.left_o), 32'h1111);
    chk("ovr_right_held", 32'(fif.right_o), 32'h2222);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    exp_q.push_back(32'h1111_2222);
    fif.frame_ready = 1'b1;
    tick(2);
    chk("ovr_valid_drop", 32'(fif.frame_valid), 32'd0);
    drain("ovr");

    // LRCK stuck low: sync_err, unlock, relock only after a fresh 1->0 boundary.
    do_reset(); preamble(); serr0 = serr_cnt;
    exp_q.push_back(32'h0101_0202);
    send_frame(32'h0101, 32'h0202, 16);
    for (int i = 0; i < 40; i++) send_bit(1'b0, (i == 0) ? prev_lsb : 1'b0);
    chk("stuck_sync_err", 32'(serr_cnt - serr0), 32'd1);
    chk("stuck_unlocked", 32'(locked), 32'd0);
    drain("stuck_first");
    prev_lsb = 1'b0;
    send_frame(32'h5555, 32'hAAAA, 16);
    exp_q.push_back(32'h1234_4321);
    send_frame(32'h1234, 32'h4321, 16);
    tail(); drain("stuck_resume");
    chk("stuck_relocked", 32'(locked), 32'd1);
    chk("stuck_one_err", 32'(serr_cnt - serr0), 32'd1);

    // Reset mid right word: immediate clear, partial data discarded.
    do_reset(); preamble();
    exp_q.push_back(32'h1357_2468);
    send_frame(32'h1357, 32'h2468, 16);
    for (int i = 0; i < 16; i++) send_bit(1'b0, (i == 0) ? prev_lsb : 1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
    drain("rst_first");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(fif.frame_valid), 32'd0);
    chk("rst_mid_left", 32'(fif.left_o), 32'd0);
    chk("rst_mid_right", 32'(fif.right_o), 32'd0);
    chk("rst_mid_locked", 32'(locked), 32'd0);
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
    prev_lsb = 1'b1;
    exp_q.push_back(32'h0F0F_F0F0);
    send_frame(32'h0F0F, 32'hF0F0, 16);
    tail(); drain("rst_after");

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
